// File: rtl/comparator_pkg.sv
// rtl/comparator_pkg.sv - shared slice width, compare result type and flag decode
package comparator_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    CMP_EQ,
    CMP_GT,
    CMP_LT
  } cmp_result_t;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_flags_t;

  function automatic cmp_flags_t result_to_flags(input cmp_result_t r);
    cmp_flags_t f;
    f = '0;
    case (r)
      CMP_EQ:  f.eq = 1'b1;
      CMP_GT:  f.gt = 1'b1;
      default: f.lt = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/comparator_8bit_cmp_slice4.sv
// rtl/comparator_8bit_cmp_slice4.sv - combinational 4-bit unsigned magnitude compare
module cmp_slice4
  import comparator_pkg::*;
(
  input  logic [SLICE_W-1:0] a4,
  input  logic [SLICE_W-1:0] b4,
  output logic               eq,
  output logic               gt,
  output logic               lt
);

  assign eq = (a4 == b4);
  assign gt = (a4 > b4);
  assign lt = (a4 < b4);

endmodule

// File: rtl/comparator_8bit.sv
// rtl/comparator_8bit.sv - registered unsigned magnitude compare built from 4-bit slices
module comparator_8bit
  import comparator_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_LSBS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             AeqB,
  output logic             AgtB,
  output logic             AltB
);

  localparam int NSLICE = WIDTH / SLICE_W;
  // Ignored LSBs are zeroed on both sides, so fully covered slices compare equal.
  localparam logic [WIDTH-1:0] MASK = {WIDTH{1'b1}} << APPROX_LSBS;

  logic [WIDTH-1:0]  a_m;
  logic [WIDTH-1:0]  b_m;
  logic [NSLICE-1:0] slice_eq;
  logic [NSLICE-1:0] slice_gt;
  logic [NSLICE-1:0] slice_lt;

  assign a_m = a & MASK;
  assign b_m = b & MASK;

  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    cmp_slice4 u_slice (
      .a4 (a_m[i*SLICE_W +: SLICE_W]),
      .b4 (b_m[i*SLICE_W +: SLICE_W]),
      .eq (slice_eq[i]),
      .gt (slice_gt[i]),
      .lt (slice_lt[i])
    );
  end

  cmp_result_t result;
  logic        found;

  always_comb begin
    result = CMP_EQ;
    found  = 1'b0;
    for (int i = NSLICE - 1; i >= 0; i--) begin
      if (!found && !slice_eq[i]) begin
        found  = 1'b1;
        result = slice_gt[i] ? CMP_GT : (slice_lt[i] ? CMP_LT : CMP_EQ);
      end
    end
  end

  logic       out_valid_d, out_valid_q;
  cmp_flags_t flags_d, flags_q;

  always_comb begin
    out_valid_d = in_valid;
    flags_d     = flags_q;
    if (in_valid) begin
      flags_d = result_to_flags(result);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign AeqB      = flags_q.eq;
  assign AgtB      = flags_q.gt;
  assign AltB      = flags_q.lt;

endmodule

// File: tb/tb_comparator_8bit.sv
// tb/tb_comparator_8bit.sv - bench for exact and APPROX_LSBS=2 comparator instances
module tb_comparator_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;

  logic out_valid, AeqB, AgtB, AltB;
  logic ap_out_valid, ap_AeqB, ap_AgtB, ap_AltB;

  int total = 0;
  int bad   = 0;

  logic       ev;
  logic [2:0] ef;
  logic [2:0] efa;

  always #5 clk = ~clk;

  comparator_8bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .AeqB      (AeqB),
    .AgtB      (AgtB),
    .AltB      (AltB)
  );

  comparator_8bit #(.WIDTH(8), .APPROX_LSBS(2)) dut_ap (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (ap_out_valid),
    .AeqB      (ap_AeqB),
    .AgtB      (ap_AgtB),
    .AltB      (ap_AltB)
  );

  function automatic logic [2:0] ref_flags(input int unsigned x, input int unsigned y);
    if (x == y)     return 3'b100;
    else if (x > y) return 3'b010;
    else            return 3'b001;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic v,
                      input logic [7:0] x, input logic [7:0] y);
    rst = r; in_valid = v; a = x; b = y;
    @(posedge clk);
    #1;
    if (r) begin
      ev = 1'b0; ef = 3'b000; efa = 3'b000;
    end else begin
      ev = v;
      if (v) begin
        ef  = ref_flags(x, y);
        efa = ref_flags(x / 4, y / 4);
      end
    end
    check({tag, " exact"},  {out_valid, AeqB, AgtB, AltB},            {ev, ef});
    check({tag, " approx"}, {ap_out_valid, ap_AeqB, ap_AgtB, ap_AltB}, {ev, efa});
  endtask

  initial begin
    ev = 1'b0; ef = 3'b000; efa = 3'b000;
    rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00;
    #1;
    step("reset0", 1'b1, 1'b0, 8'h00, 8'h00);
    step("idle_after_reset", 1'b0, 1'b0, 8'h00, 8'h00);

    step("eq_00_00", 1'b0, 1'b1, 8'h00, 8'h00);
    step("eq_80_80", 1'b0, 1'b1, 8'h80, 8'h80);
    step("eq_ff_ff", 1'b0, 1'b1, 8'hFF, 8'hFF);
    step("gt_aa_55", 1'b0, 1'b1, 8'hAA, 8'h55);
    step("gt_ff_01", 1'b0, 1'b1, 8'hFF, 8'h01);
    step("gt_ff_00", 1'b0, 1'b1, 8'hFF, 8'h00);
    step("gt_81_80", 1'b0, 1'b1, 8'h81, 8'h80);
    step("lt_55_aa", 1'b0, 1'b1, 8'h55, 8'hAA);
    step("lt_01_ff", 1'b0, 1'b1, 8'h01, 8'hFF);
    step("lt_7f_80", 1'b0, 1'b1, 8'h7F, 8'h80);
    step("lownib_34_37", 1'b0, 1'b1, 8'h34, 8'h37);

    step("hold_load", 1'b0, 1'b1, 8'hAA, 8'h55);
    for (int i = 0; i < 3; i++) step("hold", 1'b0, 1'b0, 8'h12, 8'h34);
    step("mid_reset", 1'b1, 1'b0, 8'h00, 8'h00);
    step("reset_with_valid", 1'b1, 1'b1, 8'h10, 8'h10);

    step("b2b_00_01", 1'b0, 1'b1, 8'h00, 8'h01);
    step("b2b_01_00", 1'b0, 1'b1, 8'h01, 8'h00);
    step("b2b_01_01", 1'b0, 1'b1, 8'h01, 8'h01);

    step("ap_83_80", 1'b0, 1'b1, 8'h83, 8'h80);
    step("ap_84_80", 1'b0, 1'b1, 8'h84, 8'h80);
    step("ap_7f_80", 1'b0, 1'b1, 8'h7F, 8'h80);

    for (int i = 0; i < 300; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra ^ 8'($urandom_range(0, 3)) : 8'($urandom);
      step("random", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
